// File: rtl/cu_flag_unit.sv
// cu_flag_unit: condition-flag writeback with a single pending stage.
// A qualified write is captured into the pending stage, forwarded
// combinationally to FlagsA/FlagsB, and committed on the following edge.
// A shadow copy supports save/restore. Restore wins over commit and capture.
module cu_flag_unit (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Valid,
  input  logic       CondExIn,
  input  logic [1:0] FlagWE,
  input  logic [3:0] ALUFlags,
  input  logic       Stall,
  input  logic       Flush,
  input  logic       SaveReq,
  input  logic       RestoreReq,
  output logic [1:0] FlagsA,
  output logic [1:0] FlagsB,
  output logic       Busy,
  output logic [7:0] WriteCount
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       cap;
  logic       cap_eff;
  logic       pend_valid;
  logic       commit;
  logic [1:0] pend_we;
  logic [3:0] pend_flags;
  logic [1:0] reg_a;
  logic [1:0] reg_b;
  logic [3:0] shadow;
  logic [1:0] pend_a;
  logic [1:0] pend_b;

  // Saturating increment for the commit counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Write qualification; a restore in the same cycle discards the capture,
  // and also discards the commit of whatever is pending.
  always_comb begin
    cap     = Valid & CondExIn & (|FlagWE) & ~Stall & ~Flush;
    cap_eff = cap & ~RestoreReq;
    commit  = pend_valid & ~RestoreReq;
  end

  // ALUFlags is {N,Z,C,V}; the A group is {Z,N}, the B group is {C,V}.
  always_comb begin
    pend_a = {pend_flags[2], pend_flags[3]};
    pend_b = pend_flags[1:0];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next state: a capture keeps/enters PEND, otherwise drain to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cap_eff)  state_nxt = PEND;
      PEND:    if (!cap_eff) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign pend_valid = (state == PEND);

  // Pending stage: payload only reloads on an effective capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_we    <= 2'b00;
      pend_flags <= 4'b0000;
    end else if (cap_eff) begin
      pend_we    <= FlagWE;
      pend_flags <= ALUFlags;
    end
  end

  // Committed flags: restore from shadow, else commit the pending write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_a <= 2'b00;
      reg_b <= 2'b00;
    end else if (RestoreReq) begin
      reg_a <= shadow[3:2];
      reg_b <= shadow[1:0];
    end else if (commit) begin
      if (pend_we[1]) reg_a <= pend_a;
      if (pend_we[0]) reg_b <= pend_b;
    end
  end

  // Shadow copy of the forwarded view; a simultaneous restore keeps it intact.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     shadow <= 4'b0000;
    else if (SaveReq && !RestoreReq)  shadow <= {FlagsA, FlagsB};
  end

  // Commit counter, saturating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    WriteCount <= 8'h00;
    else if (commit) WriteCount <= sat_inc(WriteCount);
  end

  // Forwarded view: a pending write overrides the committed value per group.
  always_comb begin
    FlagsA = (pend_valid & pend_we[1]) ? pend_a : reg_a;
    FlagsB = (pend_valid & pend_we[0]) ? pend_b : reg_b;
    Busy   = pend_valid;
  end

endmodule

// File: tb/tb_cu_flag_unit.sv
// tb_cu_flag_unit: table-driven directed vectors for cu_flag_unit plus
// hand-written sequences for async reset and counter saturation.
module tb_cu_flag_unit;

  logic       clk;
  logic       reset_n;
  logic       Valid;
  logic       CondExIn;
  logic [1:0] FlagWE;
  logic [3:0] ALUFlags;
  logic       Stall;
  logic       Flush;
  logic       SaveReq;
  logic       RestoreReq;
  logic [1:0] FlagsA;
  logic [1:0] FlagsB;
  logic       Busy;
  logic [7:0] WriteCount;

  int checks;
  int errors;

  typedef struct {
    logic       v;
    logic       c;
    logic [1:0] we;
    logic [3:0] alu;
    logic       st;
    logic       fl;
    logic       sv;
    logic       rs;
    logic [1:0] ea;
    logic [1:0] eb;
    logic       ebusy;
    logic [7:0] ecnt;
  } vec_t;

  vec_t vecs[64];
  int   nvec;

  cu_flag_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .Valid      (Valid),
    .CondExIn   (CondExIn),
    .FlagWE     (FlagWE),
    .ALUFlags   (ALUFlags),
    .Stall      (Stall),
    .Flush      (Flush),
    .SaveReq    (SaveReq),
    .RestoreReq (RestoreReq),
    .FlagsA     (FlagsA),
    .FlagsB     (FlagsB),
    .Busy       (Busy),
    .WriteCount (WriteCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic v, input logic c, input logic [1:0] we,
                     input logic [3:0] alu, input logic st, input logic fl,
                     input logic sv, input logic rs, input logic [1:0] ea,
                     input logic [1:0] eb, input logic ebusy, input logic [7:0] ecnt);
    vecs[nvec] = '{v, c, we, alu, st, fl, sv, rs, ea, eb, ebusy, ecnt};
    nvec++;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] ea, input logic [1:0] eb,
                           input logic ebusy, input logic [7:0] ecnt);
    check({tag, " FlagsA"},     {6'd0, FlagsA}, {6'd0, ea});
    check({tag, " FlagsB"},     {6'd0, FlagsB}, {6'd0, eb});
    check({tag, " Busy"},       {7'd0, Busy},   {7'd0, ebusy});
    check({tag, " WriteCount"}, WriteCount,     ecnt);
  endtask

  task automatic drive(input logic v, input logic c, input logic [1:0] we,
                       input logic [3:0] alu, input logic st, input logic fl,
                       input logic sv, input logic rs);
    Valid = v; CondExIn = c; FlagWE = we; ALUFlags = alu;
    Stall = st; Flush = fl; SaveReq = sv; RestoreReq = rs;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    #12;
    reset_n = 1'b1;
    #2;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    nvec    = 0;
    reset_n = 1'b1;
    idle();
    #2;
    reset_n = 1'b0;
    #1;
    check_all("reset", 2'b00, 2'b00, 1'b0, 8'h00);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    #1;

    //   v  c  we     alu      st fl sv rs  A      B      busy cnt
    // condition false / invalid / no enables
    add(1, 0, 2'b11, 4'b1111, 0, 0, 0, 0, 2'b00, 2'b00, 0, 8'd0);
    add(0, 1, 2'b11, 4'b1111, 0, 0, 0, 0, 2'b00, 2'b00, 0, 8'd0);
    add(1, 1, 2'b00, 4'b1111, 0, 0, 0, 0, 2'b00, 2'b00, 0, 8'd0);
    // flush, stall, both
    add(1, 1, 2'b11, 4'b1111, 0, 1, 0, 0, 2'b00, 2'b00, 0, 8'd0);
    add(1, 1, 2'b11, 4'b1111, 1, 0, 0, 0, 2'b00, 2'b00, 0, 8'd0);
    add(1, 1, 2'b11, 4'b1111, 1, 1, 0, 0, 2'b00, 2'b00, 0, 8'd0);
    // single write to A
    add(1, 1, 2'b10, 4'b0100, 0, 0, 0, 0, 2'b10, 2'b00, 1, 8'd0);
    add(0, 0, 2'b00, 4'b0000, 0, 0, 0, 0, 2'b10, 2'b00, 0, 8'd1);
    // back-to-back A then B
    add(1, 1, 2'b10, 4'b0100, 0, 0, 0, 0, 2'b10, 2'b00, 1, 8'd1);
    add(1, 1, 2'b01, 4'b0010, 0, 0, 0, 0, 2'b10, 2'b10, 1, 8'd2);
    add(0, 0, 2'b00, 4'b0000, 0, 0, 0, 0, 2'b10, 2'b10, 0, 8'd3);
    // both groups: N=1,Z=0,C=1,V=1
    add(1, 1, 2'b11, 4'b1011, 0, 0, 0, 0, 2'b01, 2'b11, 1, 8'd3);
    add(0, 0, 2'b00, 4'b0000, 0, 0, 0, 0, 2'b01, 2'b11, 0, 8'd4);
    // flush while pending: pending still commits, nothing new captured
    add(1, 1, 2'b10, 4'b0100, 0, 0, 0, 0, 2'b10, 2'b11, 1, 8'd4);
    add(1, 1, 2'b11, 4'b0000, 0, 1, 0, 0, 2'b10, 2'b11, 0, 8'd5);
    // stall while pending
    add(1, 1, 2'b01, 4'b0001, 0, 0, 0, 0, 2'b10, 2'b01, 1, 8'd5);
    add(1, 1, 2'b11, 4'b1111, 1, 0, 0, 0, 2'b10, 2'b01, 0, 8'd6);
    // save {10,01}, overwrite A, restore alongside a capture
    add(0, 0, 2'b00, 4'b0000, 0, 0, 1, 0, 2'b10, 2'b01, 0, 8'd6);
    add(1, 1, 2'b10, 4'b1000, 0, 0, 0, 0, 2'b01, 2'b01, 1, 8'd6);
    add(0, 0, 2'b00, 4'b0000, 0, 0, 0, 0, 2'b01, 2'b01, 0, 8'd7);
    add(1, 1, 2'b11, 4'b1111, 0, 0, 0, 1, 2'b10, 2'b01, 0, 8'd7);
    add(0, 0, 2'b00, 4'b0000, 0, 0, 0, 0, 2'b10, 2'b01, 0, 8'd7);
    // restore discards a pending commit
    add(1, 1, 2'b11, 4'b1011, 0, 0, 0, 0, 2'b01, 2'b11, 1, 8'd7);
    add(0, 0, 2'b00, 4'b0000, 0, 0, 0, 1, 2'b10, 2'b01, 0, 8'd7);
    add(0, 0, 2'b00, 4'b0000, 0, 0, 0, 0, 2'b10, 2'b01, 0, 8'd7);
    // save+restore together: old shadow used and kept
    add(1, 1, 2'b11, 4'b1011, 0, 0, 0, 0, 2'b01, 2'b11, 1, 8'd7);
    add(0, 0, 2'b00, 4'b0000, 0, 0, 0, 0, 2'b01, 2'b11, 0, 8'd8);
    add(0, 0, 2'b00, 4'b0000, 0, 0, 1, 1, 2'b10, 2'b01, 0, 8'd8);
    add(1, 1, 2'b11, 4'b0000, 0, 0, 0, 0, 2'b00, 2'b00, 1, 8'd8);
    add(0, 0, 2'b00, 4'b0000, 0, 0, 0, 0, 2'b00, 2'b00, 0, 8'd9);
    add(0, 0, 2'b00, 4'b0000, 0, 0, 0, 1, 2'b10, 2'b01, 0, 8'd9);
    // save during pending captures the forwarded value
    add(1, 1, 2'b10, 4'b1000, 0, 0, 0, 0, 2'b01, 2'b01, 1, 8'd9);
    add(0, 0, 2'b00, 4'b0000, 0, 0, 1, 0, 2'b01, 2'b01, 0, 8'd10);
    add(1, 1, 2'b11, 4'b0100, 0, 0, 0, 0, 2'b10, 2'b00, 1, 8'd10);
    add(0, 0, 2'b00, 4'b0000, 0, 0, 0, 0, 2'b10, 2'b00, 0, 8'd11);
    add(0, 0, 2'b00, 4'b0000, 0, 0, 0, 1, 2'b01, 2'b01, 0, 8'd11);

    for (int i = 0; i < nvec; i++) begin
      drive(vecs[i].v, vecs[i].c, vecs[i].we, vecs[i].alu,
            vecs[i].st, vecs[i].fl, vecs[i].sv, vecs[i].rs);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].ebusy, vecs[i].ecnt);
    end

    // reset in flight: pending write must vanish without commit
    do_reset();
    check_all("rst2", 2'b00, 2'b00, 1'b0, 8'd0);
    drive(1'b1, 1'b1, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_all("inflight", 2'b11, 2'b11, 1'b1, 8'd0);
    idle();
    #2;
    reset_n = 1'b0;
    #1;
    check_all("async_rst", 2'b00, 2'b00, 1'b0, 8'd0);
    step();
    #2;
    reset_n = 1'b1;
    step();
    check_all("post_rst1", 2'b00, 2'b00, 1'b0, 8'd0);
    step();
    check_all("post_rst2", 2'b00, 2'b00, 1'b0, 8'd0);

    // counter saturation with a continuous stream of writes
    drive(1'b1, 1'b1, 2'b01, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) step();
    check_all("stream10", 2'b00, 2'b11, 1'b1, 8'd9);
    for (int k = 0; k < 300; k++) step();
    idle();
    step();
    check_all("saturate", 2'b00, 2'b11, 1'b0, 8'hFF);
    drive(1'b1, 1'b1, 2'b10, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    step();
    check_all("sat_hold", 2'b10, 2'b11, 1'b0, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
